// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Wide enough for STARVE_LIMIT up to 15.
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave = arbiter, master = caches + memory.
interface mem_arbiter_if #(
  parameter int unsigned CACHE_LINE_SIZE = 128
);
  logic                       in_i_read_en;
  logic [31:0]                in_i_addr;
  logic                       out_i_ready;
  logic                       in_d_read_en;
  logic                       in_d_write_en;
  logic [31:0]                in_d_addr;
  logic [CACHE_LINE_SIZE-1:0] in_d_write_data;
  logic                       out_d_ready;
  logic [CACHE_LINE_SIZE-1:0] out_read_data;
  logic                       out_mem_read_en;
  logic                       out_mem_write_en;
  logic [31:0]                out_mem_addr;
  logic [CACHE_LINE_SIZE-1:0] out_mem_write_data;
  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data;
  logic                       in_mem_ready;

  modport slave (
    input  in_i_read_en, in_i_addr, in_d_read_en, in_d_write_en, in_d_addr,
           in_d_write_data, in_mem_read_data, in_mem_ready,
    output out_i_ready, out_d_ready, out_read_data, out_mem_read_en,
           out_mem_write_en, out_mem_addr, out_mem_write_data
  );

  modport master (
    output in_i_read_en, in_i_addr, in_d_read_en, in_d_write_en, in_d_addr,
           in_d_write_data, in_mem_read_data, in_mem_ready,
    input  out_i_ready, out_d_ready, out_read_data, out_mem_read_en,
           out_mem_write_en, out_mem_addr, out_mem_write_data
  );
endinterface

// File: rtl/mem_arbiter_priority_sel.sv
// Winner select (D over I unless I is starved) and next starve count for a grant.
module arb_priority_sel
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_valid,
  output logic                winner,
  output logic [STARVE_W-1:0] starve_next
);

  logic starved;

  always_comb begin
    grant_valid = i_req | d_req;
    starved     = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    winner      = (d_req && !(i_req && starved)) ? REQ_D : REQ_I;
    starve_next = starve_cnt;
    if (grant_valid) begin
      if (winner == REQ_I || !i_req) begin
        starve_next = '0;
      end else if (!starved) begin
        starve_next = starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache arbiter for the shared line-granular memory port, registered memory outputs.
// Optional MEM_ARB_PERF_EN adds grant and I-wait performance counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]  out_perf_i_grants,
  output logic [31:0]  out_perf_d_grants,
  output logic [31:0]  out_perf_i_wait_cycles
`endif
);

  arb_state_t                 state_q, state_d;
  logic [STARVE_W-1:0]        starve_q, starve_d, starve_next;
  logic                       rd_q, rd_d, wr_q, wr_d;
  logic [31:0]                addr_q, addr_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic                       grant_valid, winner;
  logic                       i_ready, d_ready;

  arb_priority_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .i_req       (bus.in_i_read_en),
    .d_req       (bus.in_d_read_en | bus.in_d_write_en),
    .starve_cnt  (starve_q),
    .grant_valid (grant_valid),
    .winner      (winner),
    .starve_next (starve_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          starve_d = starve_next;
          if (winner == REQ_D) begin
            state_d = ARB_BUSY_D;
            // Simultaneous read+write from D is illegal: the writeback wins.
            wr_d    = bus.in_d_write_en;
            rd_d    = bus.in_d_read_en & ~bus.in_d_write_en;
            addr_d  = bus.in_d_addr;
            wdata_d = bus.in_d_write_data;
          end else begin
            state_d = ARB_BUSY_I;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            addr_d  = bus.in_i_addr;
            wdata_d = '0;
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus.in_mem_ready) begin
          i_ready = (state_q == ARB_BUSY_I);
          d_ready = (state_q == ARB_BUSY_D);
          state_d = ARB_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.out_i_ready        = i_ready;
  assign bus.out_d_ready        = d_ready;
  assign bus.out_read_data      = bus.in_mem_read_data;
  assign bus.out_mem_read_en    = rd_q;
  assign bus.out_mem_write_en   = wr_q;
  assign bus.out_mem_addr       = addr_q;
  assign bus.out_mem_write_data = wdata_q;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_perf_i_grants      <= '0;
      out_perf_d_grants      <= '0;
      out_perf_i_wait_cycles <= '0;
    end else begin
      if (state_q == ARB_IDLE && grant_valid) begin
        if (winner == REQ_I) out_perf_i_grants <= out_perf_i_grants + 1'b1;
        else                 out_perf_d_grants <= out_perf_d_grants + 1'b1;
      end
      if (bus.in_i_read_en && state_q != ARB_BUSY_I)
        out_perf_i_wait_cycles <= out_perf_i_wait_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (perf counters checked when MEM_ARB_PERF_EN is defined).
module tb_mem_arbiter;
  localparam int unsigned LW = 128;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   i_pulses = 0;
  int   d_pulses = 0;

  mem_arbiter_if #(.CACHE_LINE_SIZE(LW)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i, perf_d, perf_w;
`endif

  mem_arbiter #(.CACHE_LINE_SIZE(LW), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .out_perf_i_grants      (perf_i),
    .out_perf_d_grants      (perf_d),
    .out_perf_i_wait_cycles (perf_w)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_i_ready === 1'b1) i_pulses++;
    if (bus.out_d_ready === 1'b1) d_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read grant started from IDLE with the requests already set; returns in the IDLE gap cycle.
  task automatic grant(input string tag, input logic exp_d, input logic [31:0] exp_addr);
    step();
    check({tag, "_rd"}, 128'(bus.out_mem_read_en), 128'(1'b1));
    check({tag, "_addr"}, 128'(bus.out_mem_addr), 128'(exp_addr));
    bus.in_mem_ready = 1'b1;
    #1;
    check({tag, "_iready"}, 128'(bus.out_i_ready), 128'(!exp_d));
    check({tag, "_dready"}, 128'(bus.out_d_ready), 128'(exp_d));
    step();
    bus.in_mem_ready = 1'b0;
    check({tag, "_gap"}, 128'(bus.out_mem_read_en), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pat_a, pat_5;
    int i0, d0;
    pat_a = {32{4'hA}};
    pat_5 = {32{4'h5}};
    reset = 1'b1;
    bus.in_i_read_en = 1'b0;  bus.in_i_addr = '0;
    bus.in_d_read_en = 1'b0;  bus.in_d_write_en = 1'b0;
    bus.in_d_addr = '0;       bus.in_d_write_data = '0;
    bus.in_mem_read_data = '0; bus.in_mem_ready = 1'b0;
    step(); step();
    check("rst_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    check("rst_wr", 128'(bus.out_mem_write_en), 128'(1'b0));
    check("rst_addr", 128'(bus.out_mem_addr), 128'(0));
    reset = 1'b0;
    bus.in_mem_read_data = pat_5;
    #1;
    check("rdata_pass", bus.out_read_data, pat_5);

    // I fill alone, ready 5 cycles after the grant
    bus.in_i_addr = 32'h1000; bus.in_i_read_en = 1'b1;
    step();
    check("t1_rd", 128'(bus.out_mem_read_en), 128'(1'b1));
    check("t1_wr", 128'(bus.out_mem_write_en), 128'(1'b0));
    check("t1_addr", 128'(bus.out_mem_addr), 128'(32'h1000));
    for (int k = 0; k < 4; k++) step();
    check("t1_hold_addr", 128'(bus.out_mem_addr), 128'(32'h1000));
    bus.in_mem_ready = 1'b1;
    #1;
    check("t1_iready", 128'(bus.out_i_ready), 128'(1'b1));
    check("t1_dready", 128'(bus.out_d_ready), 128'(1'b0));
    step();
    bus.in_mem_ready = 1'b0; bus.in_i_read_en = 1'b0;
    check("t1_drop_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    check("t1_drop_addr", 128'(bus.out_mem_addr), 128'(0));
    step();
    check("t1_idle_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    check("t1_ipulses", 128'(i_pulses), 128'(1));
    check("t1_dpulses", 128'(d_pulses), 128'(0));

    // I and D raised together: D first, then I after one IDLE cycle
    bus.in_i_addr = 32'h1100; bus.in_i_read_en = 1'b1;
    bus.in_d_addr = 32'h2200; bus.in_d_read_en = 1'b1;
    grant("t2_d", 1'b1, 32'h2200);
    bus.in_d_read_en = 1'b0;
    grant("t2_i", 1'b0, 32'h1100);
    bus.in_i_read_en = 1'b0;

    // D writeback then back-to-back fill to the same line
    bus.in_d_addr = 32'h2000; bus.in_d_write_data = pat_a; bus.in_d_write_en = 1'b1;
    step();
    check("t3_wr", 128'(bus.out_mem_write_en), 128'(1'b1));
    check("t3_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    check("t3_addr", 128'(bus.out_mem_addr), 128'(32'h2000));
    check("t3_wdata", bus.out_mem_write_data, pat_a);
    bus.in_mem_ready = 1'b1;
    #1;
    check("t3_dready", 128'(bus.out_d_ready), 128'(1'b1));
    step();
    bus.in_mem_ready = 1'b0; bus.in_d_write_en = 1'b0; bus.in_d_read_en = 1'b1;
    check("t3_gap_wr", 128'(bus.out_mem_write_en), 128'(1'b0));
    grant("t3_fill", 1'b1, 32'h2000);
    check("t3_fill_wr", 128'(bus.out_mem_write_en), 128'(1'b0));
    bus.in_d_read_en = 1'b0;

    // Illegal D read+write: only the write goes out
    bus.in_d_addr = 32'h2400; bus.in_d_write_data = pat_5;
    bus.in_d_read_en = 1'b1; bus.in_d_write_en = 1'b1;
    step();
    check("t4_wr", 128'(bus.out_mem_write_en), 128'(1'b1));
    check("t4_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    bus.in_mem_ready = 1'b1;
    step();
    bus.in_mem_ready = 1'b0; bus.in_d_read_en = 1'b0; bus.in_d_write_en = 1'b0;

    // Starvation: D,D,D,D,I repeated; second round shows the counter cleared
    bus.in_i_addr = 32'h1500; bus.in_i_read_en = 1'b1;
    bus.in_d_addr = 32'h2500; bus.in_d_read_en = 1'b1;
    for (int g = 0; g < 10; g++) begin
      if ((g % 5) == 4) grant("t5_i", 1'b0, 32'h1500);
      else              grant("t5_d", 1'b1, 32'h2500);
    end
    bus.in_i_read_en = 1'b0; bus.in_d_read_en = 1'b0;
    step();

    // Reset in the middle of a D transaction
    i0 = i_pulses; d0 = d_pulses;
    bus.in_d_addr = 32'h3000; bus.in_d_read_en = 1'b1;
    step();
    check("t6_busy_rd", 128'(bus.out_mem_read_en), 128'(1'b1));
    #2 reset = 1'b1;
    #1;
    check("t6_async_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    check("t6_async_addr", 128'(bus.out_mem_addr), 128'(0));
    bus.in_d_read_en = 1'b0;
    step();
    reset = 1'b0;
    bus.in_mem_ready = 1'b1;
    #1;
    check("t6_no_dready", 128'(bus.out_d_ready), 128'(1'b0));
    step();
    bus.in_mem_ready = 1'b0;
    check("t6_idle_rd", 128'(bus.out_mem_read_en), 128'(1'b0));
    check("t6_pulses", 128'(i_pulses - i0 + d_pulses - d0), 128'(0));

    // Counter workload: 3 I grants, 2 D grants, 5 I wait cycles
    bus.in_i_addr = 32'h1600; bus.in_i_read_en = 1'b1;
    grant("t7_i1", 1'b0, 32'h1600);
    bus.in_i_read_en = 1'b0;
    bus.in_d_addr = 32'h2600; bus.in_d_read_en = 1'b1;
    grant("t7_d1", 1'b1, 32'h2600);
    bus.in_i_read_en = 1'b1;
    grant("t7_d2", 1'b1, 32'h2600);
    bus.in_d_read_en = 1'b0;
    grant("t7_i2", 1'b0, 32'h1600);
    bus.in_i_read_en = 1'b0;
    step();
    bus.in_i_read_en = 1'b1;
    grant("t7_i3", 1'b0, 32'h1600);
    bus.in_i_read_en = 1'b0;
    step();
`ifdef MEM_ARB_PERF_EN
    check("perf_i_grants", 128'(perf_i), 128'(3));
    check("perf_d_grants", 128'(perf_d), 128'(2));
    check("perf_i_wait", 128'(perf_w), 128'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single line-granular main-memory port between the instruction cache (I) and the data cache (D).
- Each cache issues line fills and writebacks as a held request. The arbiter grants one requester at a time, drives the memory port from registered outputs, and routes the memory ready pulse back only to the winner.
- Sits between both cache instances and the memory model at the top of the core.

Parameters:
- CACHE_LINE_SIZE, 128, line width in bits for read and write data.
- STARVE_LIMIT, 4, number of consecutive D grants while I waits before I is forced to win; range 1..15.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- in_i_read_en  in  1  I-cache line fill request (I never writes)
- in_i_addr  in  32  I-cache line address
- out_i_ready  out  1  memory done pulse for I
- in_d_read_en  in  1  D-cache line fill request
- in_d_write_en  in  1  D-cache writeback request
- in_d_addr  in  32  D-cache line address
- in_d_write_data  in  CACHE_LINE_SIZE  D-cache writeback line
- out_d_ready  out  1  memory done pulse for D
- out_read_data  out  CACHE_LINE_SIZE  in_mem_read_data broadcast to both caches
- out_mem_read_en  out  1  to memory
- out_mem_write_en  out  1  to memory
- out_mem_addr  out  32  to memory
- out_mem_write_data  out  CACHE_LINE_SIZE  to memory
- in_mem_read_data  in  CACHE_LINE_SIZE  from memory
- in_mem_ready  in  1  from memory, one-cycle done pulse

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (async): state IDLE, starve counter 0, all out_mem_* 0. out_i_ready and out_d_ready are 0 in any state that does not match.
- IDLE, with any request sampled at cycle N:
  - Pick the winner, register address, data and enables, and enter BUSY_x at N+1.
  - out_mem_* are valid from N+1 and held constant until the ready pulse.
- Priority:
  - D beats I, unless the starve counter equals STARVE_LIMIT; then I wins.
  - The counter increments when D is granted while in_i_read_en is high, saturating at STARVE_LIMIT.
  - The counter clears when I is granted, or when D is granted with I idle.
- D with both read_en and write_en high is illegal. The arbiter issues the write only, with read_en forced 0.
- BUSY_x with in_mem_ready high:
  - out_x_ready = 1 combinationally in the same cycle; the other ready stays 0.
  - out_mem_* drop to 0 at the next edge and state returns to IDLE.
  - Minimum gap between two grants is 1 IDLE cycle.
- Requester handshake: hold the request until its ready pulse, then deassert it in the next cycle.
- A request still high in the IDLE cycle after ready is treated as a new request. This is legal back-to-back, e.g. D writeback followed by a fill.
- Requester dropping its request mid-transaction: the transaction continues, because memory cannot abort. The ready pulse is still driven and the winner ignores it.
- in_mem_ready while IDLE is ignored.
- Reset mid-transaction: outputs 0 immediately. A later in_mem_ready is ignored.
- out_read_data = in_mem_read_data, combinational and unconditioned.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds 32-bit outputs out_perf_i_grants, out_perf_d_grants and out_perf_i_wait_cycles.
  - The wait counter counts cycles with in_i_read_en high and state not BUSY_I.
  - All three reset to 0 and wrap on overflow.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package: state enum (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D) and the requester ID constants (REQ_I = 0, REQ_D = 1).
- One natural sub-module, arb_priority_sel: combinational winner select plus the starve counter update.

Test Plan:
- I fill alone at 0x1000, memory ready 5 cycles after the grant:
  - out_mem_read_en = 1 and out_mem_addr = 0x1000 from N+1.
  - out_i_ready pulses exactly once; out_d_ready stays 0.
- I read and D read both raised in the same cycle: D is granted first, I immediately after D's ready, with a 1-cycle IDLE gap.
- D writeback to 0x2000 with data 0xAAAA..., followed by a fill to 0x2000 held back-to-back:
  - Write issued first with out_mem_write_en = 1 and read_en = 0.
  - The read follows, with no I interleave while I is idle.
- D requests continuously while I waits, STARVE_LIMIT = 4: after exactly 4 D grants the 5th grant goes to I, then the counter is 0.
- Reset asserted mid BUSY_D: outputs 0 asynchronously. A subsequent in_mem_ready produces no ready pulse, and the state is IDLE.
- MEM_ARB_PERF_EN defined, 3 I grants and 2 D grants: counters read 3 and 2, and the wait count equals the observed I wait cycles.
